data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 24 ++
 rtl/data_cache_array.sv | 57 +++++
 rtl/data_cache.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
// Shared geometry, FSM encoding and address helper
// for the direct-mapped write-back data cache.
package data_cache_pkg;
  localparam int TAG_W     = 26;
  localparam int IDX_W     = 2;
  localparam int OFF_W     = 4;
  localparam int LINE_W    = 128;
  localparam int NUM_LINES = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    FLUSH_WB,
    FLUSH_NEXT
  } state_t;

  function automatic logic [31:0] line_addr(
    input logic [TAG_W-1:0] tag,
    input logic [IDX_W-1:0] idx
  );
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage: combinational read,
// synchronous word write, line fill and bulk invalidate.
module data_cache_array
  import data_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic              o_rd_valid,
  output logic              o_rd_dirty,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_word_we,
  input  logic [IDX_W-1:0]  i_word_idx,
  input  logic [1:0]        i_word_sel,
  input  logic [31:0]       i_word_data,
  input  logic              i_line_we,
  input  logic [IDX_W-1:0]  i_line_idx,
  input  logic [TAG_W-1:0]  i_line_tag,
  input  logic [LINE_W-1:0] i_line_data,
  input  logic              i_inval
);
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;

  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_inval) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_line_idx] <= 1'b1;
      r_dirty[i_line_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_word_idx] <= 1'b1;
    end
  end

  // Contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (i_line_we) begin
      r_tag[i_line_idx]  <= i_line_tag;
      r_data[i_line_idx] <= i_line_data;
    end else if (i_word_we) begin
      r_data[i_word_idx][{i_word_sel, 5'b0} +: 32] <= i_word_data;
    end
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache
// with line writeback/fill port and full-cache flush.
module data_cache
  import data_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       address,
  input  logic [31:0]       writedata,
  output logic              requested_data_to_mem,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic [LINE_W-1:0] dmem_wdata,
  input  logic [LINE_W-1:0] dmem_rdata,
  input  logic              dmem_ready
);
  state_t           r_state;
  logic [IDX_W-1:0] r_fidx;
  logic             r_flush_pending;

  logic [TAG_W-1:0]  w_req_tag;
  logic [IDX_W-1:0]  w_req_idx;
  logic [1:0]        w_word;
  logic              w_unused_addr;
  logic              w_flushing;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [TAG_W-1:0]  w_rd_tag;
  logic              w_rd_valid;
  logic              w_rd_dirty;
  logic [LINE_W-1:0] w_rd_line;
  logic [31:0]       w_rd_word;
  logic              w_req;
  logic              w_hit;
  logic              w_victim_dirty;
  logic              w_accept;
  logic              w_line_we;
  logic              w_inval;

  assign w_req_tag     = address[31:6];
  assign w_req_idx     = address[5:4];
  assign w_word        = address[3:2];
  assign w_unused_addr = &{1'b0, address[1:0]};

  assign w_flushing = (r_state == FLUSH_WB) ||
                      (r_state == FLUSH_NEXT);
  assign w_rd_idx   = w_flushing ? r_fidx : w_req_idx;
  assign w_rd_word  = w_rd_line[{w_word, 5'b0} +: 32];

  assign w_req          = mem_read | mem_write;
  assign w_hit          = w_rd_valid && (w_rd_tag == w_req_tag);
  assign w_victim_dirty = w_rd_valid && w_rd_dirty;

  assign requested_data_to_mem = (r_state != IDLE) ||
                                 (w_req && !w_hit) ||
                                 r_flush_pending;
  assign w_accept  = w_req && !requested_data_to_mem;
  assign w_line_we = (r_state == ALLOCATE) && dmem_ready;

  // Last flush slot: clean line 3, or writeback of line 3 done.
  assign w_inval =
    ((r_state == FLUSH_NEXT) && (r_fidx == 2'd3) && !w_victim_dirty) ||
    ((r_state == FLUSH_WB) && dmem_ready && (r_fidx == 2'd3));

  data_cache_array u_array (
    .clk         (clk),
    .reset       (reset),
    .i_rd_idx    (w_rd_idx),
    .o_rd_tag    (w_rd_tag),
    .o_rd_valid  (w_rd_valid),
    .o_rd_dirty  (w_rd_dirty),
    .o_rd_line   (w_rd_line),
    .i_word_we   (w_accept && mem_write),
    .i_word_idx  (w_req_idx),
    .i_word_sel  (w_word),
    .i_word_data (writedata),
    .i_line_we   (w_line_we),
    .i_line_idx  (w_req_idx),
    .i_line_tag  (w_req_tag),
    .i_line_data (dmem_rdata),
    .i_inval     (w_inval)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_fidx          <= '0;
      r_flush_pending <= 1'b0;
      read_valid      <= 1'b0;
      read_data       <= '0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
    end else begin
      read_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_flush_pending) begin
            r_state <= FLUSH_NEXT;
            r_fidx  <= '0;
          end else if (w_accept) begin
            if (!mem_write) begin
              read_valid <= 1'b1;
              read_data  <= w_rd_word;
            end
          end else if (w_req) begin
            dmem_req <= 1'b1;
            if (w_victim_dirty) begin
              r_state    <= WRITEBACK;
              dmem_we    <= 1'b1;
              dmem_addr  <= line_addr(w_rd_tag, w_req_idx);
              dmem_wdata <= w_rd_line;
            end else begin
              r_state   <= ALLOCATE;
              dmem_we   <= 1'b0;
              dmem_addr <= line_addr(w_req_tag, w_req_idx);
            end
          end
        end
        WRITEBACK: begin
          if (dmem_ready) begin
            r_state   <= ALLOCATE;
            dmem_we   <= 1'b0;
            dmem_addr <= line_addr(w_req_tag, w_req_idx);
          end
        end
        ALLOCATE: begin
          if (dmem_ready) begin
            r_state  <= IDLE;
            dmem_req <= 1'b0;
          end
        end
        FLUSH_NEXT: begin
          if (w_victim_dirty) begin
            r_state    <= FLUSH_WB;
            dmem_req   <= 1'b1;
            dmem_we    <= 1'b1;
            dmem_addr  <= line_addr(w_rd_tag, r_fidx);
            dmem_wdata <= w_rd_line;
          end else if (r_fidx == 2'd3) begin
            r_state         <= IDLE;
            r_fidx          <= '0;
            r_flush_pending <= 1'b0;
          end else begin
            r_fidx <= r_fidx + 2'd1;
          end
        end
        FLUSH_WB: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (r_fidx == 2'd3) begin
              r_state         <= IDLE;
              r_fidx          <= '0;
              r_flush_pending <= 1'b0;
            end else begin
              r_state <= FLUSH_NEXT;
              r_fidx  <= r_fidx + 2'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // A new flush request overrides completion of the current walk.
      if (flush) r_flush_pending <= 1'b1;
    end
  end
endmodule
